// File: rtl/pong_bar_ctrl.sv
// pong_bar_ctrl -- paddle (bar) position controller behind an Avalon-MM slave.
//
// Each accepted video frame runs one update. In auto mode an ADC sample is
// taken and scaled into [min,max]. In manual mode the MANUAL_Y register is
// clamped to [min,max]. The bar then moves toward the target by at most
// STEP per frame, where STEP=0 means the move is unlimited.
//
// Ports
//   clk, reset_n           system clock, asynchronous active-low reset
//   address, chipselect,   Avalon-MM slave: word address, select,
//   write_n, writedata     active-low write strobe, write data
//   readdata               combinational read data, zero-extended
//   adc_data, adc_valid    paddle ADC sample stream
//   adc_ready              high while waiting for a sample (CAPTURE)
//   frame_tick             one-cycle pulse per video frame
//   bar_y                  current bar position
//   irq                    level interrupt = irq_en & DONE
//
// Register map
//   0 CTRL     bit0 enable, bit1 manual, bit2 irq_en
//   1 MANUAL_Y [15:0]
//   2 LIMITS   min [15:0], max [31:16]
//   3 STEP     [15:0]
//   4 STATUS   bit0 busy (ro); bits 1..4 DONE/OVERRUN/CLAMPED/CFG_ERR, W1C
//   5 BAR_Y    read-only
//
// Y_W must not exceed 16, because min and max share one 32-bit LIMITS word.
module pong_bar_ctrl #(
    parameter int ADC_W = 12,
    parameter int Y_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             adc_valid,
    output logic             adc_ready,
    input  logic             frame_tick,
    output logic [Y_W-1:0]   bar_y,
    output logic             irq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_COMPUTE,
        S_MOVE
    } state_e;

    state_e state_q, state_d;

    // Software-visible registers
    logic             en_q, en_d, man_q, man_d, irqen_q, irqen_d;
    logic [Y_W-1:0]   manual_y_q, manual_y_d;
    logic [Y_W-1:0]   min_q, min_d, max_q, max_d;
    logic [Y_W-1:0]   step_q, step_d;
    logic             done_q, done_d, ovr_q, ovr_d;
    logic             clamp_q, clamp_d, cfg_q, cfg_d;

    // Datapath registers
    logic [Y_W-1:0]   bar_q, bar_d;
    logic [Y_W-1:0]   target_q, target_d;
    logic [ADC_W-1:0] adc_q, adc_d;
    logic             mode_q, mode_d;   // manual flag captured when the frame starts

    logic             set_done, set_ovr, set_clamp, set_cfg;
    logic             bus_we;
    logic [3:0]       w1c;
    logic             busy;

    assign bus_we = chipselect & ~write_n;
    assign busy   = (state_q != S_IDLE);

    // ------------------------------------------------------------------
    // Target arithmetic
    // ------------------------------------------------------------------
    logic [Y_W-1:0]       span;
    logic [ADC_W+Y_W-1:0] prod;
    logic [Y_W-1:0]       auto_tgt, man_tgt;
    logic [Y_W-1:0]       diff, moved;
    logic                 cfg_bad;

    assign cfg_bad  = (min_q > max_q);
    assign span     = max_q - min_q;
    // Full-width product, so no bits are lost before the scaling shift.
    assign prod     = (ADC_W+Y_W)'(adc_q) * (ADC_W+Y_W)'(span);
    // The scaled offset is strictly below span, so the sum stays within max.
    assign auto_tgt = min_q + Y_W'(prod >> ADC_W);
    assign man_tgt  = (manual_y_q < min_q) ? min_q :
                      (manual_y_q > max_q) ? max_q : manual_y_q;

    // Slew limiting. The step is applied only when diff > step, so neither
    // direction can wrap around.
    assign diff  = (target_q >= bar_q) ? (target_q - bar_q) : (bar_q - target_q);
    assign moved = ((step_q == '0) || (diff <= step_q)) ? target_q :
                   (target_q > bar_q) ? (bar_q + step_q) : (bar_q - step_q);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        adc_ready = 1'b0;
        set_done  = 1'b0;
        set_ovr   = 1'b0;
        set_clamp = 1'b0;
        set_cfg   = 1'b0;
        adc_d     = adc_q;
        target_d  = target_q;
        bar_d     = bar_q;
        mode_d    = mode_q;

        if (busy && frame_tick) set_ovr = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (frame_tick && en_q) begin
                    mode_d  = man_q;
                    state_d = man_q ? S_COMPUTE : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                adc_ready = 1'b1;
                if (adc_valid) begin
                    adc_d   = adc_data;
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (cfg_bad) begin
                    set_cfg = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    target_d  = mode_q ? man_tgt : auto_tgt;
                    set_clamp = mode_q && (man_tgt != manual_y_q);
                    state_d   = S_MOVE;
                end
            end
            S_MOVE: begin
                bar_d    = moved;
                set_done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Disabling mid-sequence abandons the frame. The bar is not touched
        // and no completion flags are raised.
        if (busy && !en_q) begin
            state_d   = S_IDLE;
            bar_d     = bar_q;
            set_done  = 1'b0;
            set_clamp = 1'b0;
            set_cfg   = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Register file next-state
    // ------------------------------------------------------------------
    always_comb begin
        en_d       = en_q;
        man_d      = man_q;
        irqen_d    = irqen_q;
        manual_y_d = manual_y_q;
        min_d      = min_q;
        max_d      = max_q;
        step_d     = step_q;
        w1c        = '0;
        if (bus_we) begin
            case (address)
                3'd0: begin
                    en_d    = writedata[0];
                    man_d   = writedata[1];
                    irqen_d = writedata[2];
                end
                3'd1: manual_y_d = writedata[Y_W-1:0];
                3'd2: begin
                    min_d = writedata[Y_W-1:0];
                    max_d = writedata[16 +: Y_W];
                end
                3'd3: step_d = writedata[Y_W-1:0];
                3'd4: w1c    = writedata[4:1];
                default: ;
            endcase
        end
        // When a hardware set and a software clear hit the same edge, the set wins.
        done_d  = (done_q  & ~w1c[0]) | set_done;
        ovr_d   = (ovr_q   & ~w1c[1]) | set_ovr;
        clamp_d = (clamp_q & ~w1c[2]) | set_clamp;
        cfg_d   = (cfg_q   & ~w1c[3]) | set_cfg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q       <= 1'b0;
            man_q      <= 1'b0;
            irqen_q    <= 1'b0;
            manual_y_q <= '0;
            min_q      <= '0;
            max_q      <= '0;
            step_q     <= '0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            clamp_q    <= 1'b0;
            cfg_q      <= 1'b0;
            bar_q      <= '0;
            target_q   <= '0;
            adc_q      <= '0;
            mode_q     <= 1'b0;
        end else begin
            en_q       <= en_d;
            man_q      <= man_d;
            irqen_q    <= irqen_d;
            manual_y_q <= manual_y_d;
            min_q      <= min_d;
            max_q      <= max_d;
            step_q     <= step_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
            clamp_q    <= clamp_d;
            cfg_q      <= cfg_d;
            bar_q      <= bar_d;
            target_q   <= target_d;
            adc_q      <= adc_d;
            mode_q     <= mode_d;
        end
    end

    // ------------------------------------------------------------------
    // Read mux and outputs
    // ------------------------------------------------------------------
    always_comb begin
        readdata = '0;
        case (address)
            3'd0: readdata = {29'b0, irqen_q, man_q, en_q};
            3'd1: readdata[Y_W-1:0] = manual_y_q;
            3'd2: begin
                readdata[Y_W-1:0]  = min_q;
                readdata[16 +: Y_W] = max_q;
            end
            3'd3: readdata[Y_W-1:0] = step_q;
            3'd4: readdata = {27'b0, cfg_q, clamp_q, ovr_q, done_q, busy};
            3'd5: readdata[Y_W-1:0] = bar_q;
            default: readdata = '0;
        endcase
    end

    assign bar_y = bar_q;
    assign irq   = irqen_q & done_q;

endmodule

// File: tb/tb_pong_bar_ctrl.sv
// Testbench for pong_bar_ctrl. The driver issues bus traffic and frames and
// keeps a behavioural model of the register file and the bar position. For
// each frame it pushes the expected bar_y, tagged with the edge count after
// which it must be visible. A monitor pops those entries and compares them
// against the bar_y port.
module tb_pong_bar_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect, write_n;
    logic [31:0] writedata, readdata;
    logic [11:0] adc_data;
    logic        adc_valid, adc_ready, frame_tick, irq;
    logic [15:0] bar_y;

    pong_bar_ctrl #(.ADC_W(12), .Y_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .adc_data(adc_data), .adc_valid(adc_valid), .adc_ready(adc_ready),
        .frame_tick(frame_tick), .bar_y(bar_y), .irq(irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct { int due; int bar; } sb_e_t;
    sb_e_t sb[$];
    sb_e_t mon_e;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            chk("bar_y", bar_y, mon_e.bar);
        end
    end

    // ---------------- reference model ----------------
    int m_ctrl, m_my, m_min, m_max, m_step, m_bar;
    bit m_done, m_ovr, m_clamp, m_cfg;

    function automatic void model_reset();
        m_ctrl = 0; m_my = 0; m_min = 0; m_max = 0; m_step = 0; m_bar = 0;
        m_done = 0; m_ovr = 0; m_clamp = 0; m_cfg = 0;
    endfunction

    function automatic int model_status();
        return (int'(m_cfg) << 4) | (int'(m_clamp) << 3) | (int'(m_ovr) << 2) | (int'(m_done) << 1);
    endfunction

    function automatic void model_frame(input bit man, input int adc);
        int t, d, ad;
        if (m_min > m_max) begin
            m_cfg = 1;
            return;
        end
        if (man) begin
            t = m_my;
            if (t < m_min) t = m_min;
            if (t > m_max) t = m_max;
            if (t != m_my) m_clamp = 1;
        end else begin
            t = m_min + (adc * (m_max - m_min)) / 4096;
        end
        d  = t - m_bar;
        ad = (d < 0) ? -d : d;
        if (m_step == 0 || ad <= m_step) m_bar = t;
        else m_bar = m_bar + ((d > 0) ? m_step : -m_step);
        m_done = 1;
    endfunction

    // ---------------- driver tasks (entered at a negedge) ----------------
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        case (a)
            3'd0: m_ctrl = int'(d[2:0]);
            3'd1: m_my = int'(d[15:0]);
            3'd2: begin m_min = int'(d[15:0]); m_max = int'(d[31:16]); end
            3'd3: m_step = int'(d[15:0]);
            3'd4: begin
                if (d[1]) m_done = 0;
                if (d[2]) m_ovr = 0;
                if (d[3]) m_clamp = 0;
                if (d[4]) m_cfg = 0;
            end
            default: ;
        endcase
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input int exp);
        address = a;
        #1;
        chk(name, readdata, exp);
    endtask

    task automatic auto_frame(input int adc);
        int k;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        adc_data = 12'(adc); adc_valid = 1'b1;
        chk("adc_ready", adc_ready, 1);
        k = cyc + 1;
        @(negedge clk);
        adc_valid = 1'b0; adc_data = 12'($urandom);
        model_frame(0, adc);
        sb.push_back('{k + 2, m_bar});
        repeat (3) @(negedge clk);
    endtask

    task automatic manual_frame();
        int t;
        frame_tick = 1'b1;
        t = cyc + 1;
        @(negedge clk);
        frame_tick = 1'b0;
        model_frame(1, 0);
        sb.push_back('{t + 2, m_bar});
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lo, hi, nfr;
        bit man;
        reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; adc_data = '0; adc_valid = 1'b0; frame_tick = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);

        // Reset state
        for (int a = 0; a < 6; a++) rd_chk("reset_reg", 3'(a), 0);
        chk("reset_bar_y", bar_y, 0);
        chk("reset_adc_ready", adc_ready, 0);
        chk("reset_irq", irq, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Auto mode, unlimited step
        wr(3'd2, 32'd400 << 16);
        wr(3'd3, 32'd0);
        wr(3'd0, 32'h1);
        rd_chk("ctrl_rb", 3'd0, 1);
        rd_chk("limits_rb", 3'd2, 400 << 16);
        auto_frame(2048);
        chk("auto_200", bar_y, 200);
        rd_chk("auto_status", 3'd4, 32'h2);
        rd_chk("bar_reg", 3'd5, 200);

        // Slew limit, saturating below max
        wr(3'd3, 32'd10);
        for (int i = 0; i < 21; i++) auto_frame(4095);
        chk("slew_399", bar_y, 399);

        // Manual mode with clamping
        wr(3'd4, 32'h1E);
        wr(3'd3, 32'd0);
        wr(3'd1, 32'd500);
        wr(3'd2, (32'd450 << 16) | 32'd20);
        wr(3'd0, 32'h3);
        manual_frame();
        chk("manual_450", bar_y, 450);
        rd_chk("clamp_status", 3'd4, 32'hA);
        wr(3'd4, 32'h8);
        rd_chk("clamp_w1c", 3'd4, 32'h2);

        // Stall in CAPTURE plus an extra tick, then abort by clearing enable
        wr(3'd4, 32'h1E);
        wr(3'd0, 32'h1);
        frame_tick = 1'b1; @(negedge clk); frame_tick = 1'b0;
        repeat (2) @(negedge clk);
        frame_tick = 1'b1; @(negedge clk); frame_tick = 1'b0;
        m_ovr = 1;
        chk("stall_adc_ready", adc_ready, 1);
        rd_chk("overrun_status", 3'd4, 32'h5);
        chk("stall_bar", bar_y, 450);
        wr(3'd0, 32'h0);
        @(negedge clk);
        rd_chk("abort_status", 3'd4, 32'h4);
        chk("abort_adc_ready", adc_ready, 0);
        chk("abort_bar", bar_y, 450);

        // Config error, then interrupt on a valid update
        wr(3'd4, 32'h1E);
        wr(3'd2, (32'd100 << 16) | 32'd300);
        wr(3'd0, 32'h5);
        auto_frame(int'($urandom_range(0, 4095)));
        chk("cfgerr_bar", bar_y, 450);
        rd_chk("cfgerr_status", 3'd4, 32'h10);
        chk("cfgerr_irq", irq, 0);
        wr(3'd4, 32'h1E);
        wr(3'd2, 32'd400 << 16);
        auto_frame(1024);
        chk("irq_bar_100", bar_y, 100);
        chk("irq_set", irq, 1);
        rd_chk("irq_status", 3'd4, 32'h2);
        wr(3'd4, 32'h2);
        chk("irq_clr", irq, 0);

        // Reset while in COMPUTE
        wr(3'd1, 32'd250);
        wr(3'd0, 32'h3);
        frame_tick = 1'b1; @(negedge clk); frame_tick = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_bar", bar_y, 0);
        for (int a = 0; a < 6; a++) rd_chk("rst_mid_reg", 3'(a), 0);
        chk("rst_mid_irq", irq, 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("post_rst_bar", bar_y, 0);
        wr(3'd2, 32'd400 << 16);
        wr(3'd1, 32'd123);
        wr(3'd0, 32'h3);
        manual_frame();
        chk("post_rst_123", bar_y, 123);

        // Randomized configurations and frames
        for (int it = 0; it < 40; it++) begin
            lo = $urandom_range(0, 500);
            hi = $urandom_range(lo, 1000);
            if ($urandom_range(0, 7) == 0) begin
                int tmp = lo; lo = hi + 1; hi = tmp;
            end
            man = 1'($urandom_range(0, 1));
            wr(3'd2, (32'(hi) << 16) | 32'(lo));
            wr(3'd3, ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 60)));
            wr(3'd1, 32'($urandom_range(0, 1100)));
            wr(3'd0, 32'h1 | (32'(man) << 1) | (32'($urandom_range(0, 1)) << 2));
            nfr = $urandom_range(1, 3);
            for (int f = 0; f < nfr; f++) begin
                if (man) manual_frame();
                else auto_frame(int'($urandom_range(0, 4095)));
            end
            rd_chk("rand_status", 3'd4, model_status());
            chk("rand_irq", irq, ((m_ctrl >> 2) & 1) & int'(m_done));
            wr(3'd4, 32'h1E);
        end

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
